// File: rtl/load_store_unit_if.sv
// CPU request/response handshake plus data-memory strobe bus for the load/store unit.
// The slave modport is the unit's view; the master modport is the CPU/memory side.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_byte;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [15:0]       resp_data;
    logic              resp_error;
    logic              mem_rd;
    logic              mem_wn;
    logic [15:0]       mem_address;
    logic [1:0]        mem_mode;
    logic [15:0]       mem_write_data;
    logic [15:0]       mem_read_data;

    modport slave (
        input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_read_data,
        output req_ready, resp_valid, resp_data, resp_error,
        output mem_rd, mem_wn, mem_address, mem_mode, mem_write_data
    );

    modport master (
        output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        output resp_ready, mem_read_data,
        input  req_ready, resp_valid, resp_data, resp_error,
        input  mem_rd, mem_wn, mem_address, mem_mode, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one CPU request, drives one memory
// strobe cycle (or rejects the request), then holds the response until taken.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 2048,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    load_store_unit_if.slave     bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_CAPT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [15:0] r_resp_data;
    logic        r_resp_error;
    logic        r_mem_rd;
    logic        r_mem_wn;
    logic [15:0] r_mem_address;
    logic [1:0]  r_mem_mode;
    logic [15:0] r_mem_write_data;
    logic        r_signed;

    logic        w_accept;
    logic        w_err;
    logic [15:0] w_load_result;

    assign w_accept = bus.req_valid && r_req_ready;

    // Misaligned word or out-of-range address is rejected before touching memory
    assign w_err = (!bus.req_byte && bus.req_addr[0])
                || (32'(bus.req_addr) >= 32'(MEM_BYTES));

    assign w_load_result = r_mem_mode[0]
        ? {{8{bus.mem_read_data[7] & r_signed}}, bus.mem_read_data[7:0]}
        : bus.mem_read_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_req_ready      <= 1'b1;
            r_resp_valid     <= 1'b0;
            r_resp_data      <= 16'h0000;
            r_resp_error     <= 1'b0;
            r_mem_rd         <= 1'b0;
            r_mem_wn         <= 1'b0;
            r_mem_address    <= 16'h0000;
            r_mem_mode       <= 2'b00;
            r_mem_write_data <= 16'h0000;
            r_signed         <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req_ready      <= 1'b0;
                        r_signed         <= bus.req_signed;
                        r_mem_address    <= 16'(bus.req_addr);
                        r_mem_mode       <= {1'b0, bus.req_byte};
                        r_mem_write_data <= bus.req_wdata;
                        if (w_err) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b1;
                            r_resp_data  <= 16'h0000;
                        end else if (bus.req_write) begin
                            r_state  <= S_WRITE;
                            r_mem_wn <= 1'b1;
                        end else begin
                            r_state  <= S_READ;
                            r_mem_rd <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_mem_wn     <= 1'b0;
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_error <= 1'b0;
                    r_resp_data  <= 16'h0000;
                end
                S_READ: begin
                    r_mem_rd <= 1'b0;
                    r_state  <= S_CAPT;
                end
                // Memory registered its read data at the end of READ
                S_CAPT: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_error <= 1'b0;
                    r_resp_data  <= w_load_result;
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_mem_rd     <= 1'b0;
                    r_mem_wn     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready      = r_req_ready;
    assign bus.resp_valid     = r_resp_valid;
    assign bus.resp_data      = r_resp_data;
    assign bus.resp_error     = r_resp_error;
    assign bus.mem_rd         = r_mem_rd;
    assign bus.mem_wn         = r_mem_wn;
    assign bus.mem_address    = r_mem_address;
    assign bus.mem_mode       = r_mem_mode;
    assign bus.mem_write_data = r_mem_write_data;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed and random checks of load_store_unit against a byte-array reference,
// with a behavioural memory attached to the strobe bus.
module tb_load_store_unit;
    localparam int unsigned MEM_BYTES = 2048;
    localparam int unsigned ADDR_W    = 16;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();
    load_store_unit #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] data;
        logic        error;
        int          lat;
        logic        is_load;
        logic        is_store;
    } exp_t;

    logic [7:0] mem     [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];
    exp_t       sb [$];
    int         checks   = 0;
    int         fails    = 0;
    int         both_cnt = 0;

    // Memory: commits writes on the falling edge, registers reads on the rising edge
    always @(negedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = 8'(i * 37 + 5);
        end else if (bus.mem_wn) begin
            if (bus.mem_mode == 2'b01) begin
                mem[int'(bus.mem_address)] = bus.mem_write_data[7:0];
            end else begin
                mem[int'(bus.mem_address)]     = bus.mem_write_data[15:8];
                mem[int'(bus.mem_address) + 1] = bus.mem_write_data[7:0];
            end
        end
    end

    always @(posedge clk) begin
        if (bus.mem_rd) begin
            if (bus.mem_mode == 2'b01)
                bus.mem_read_data <= {8'hA5, mem[int'(bus.mem_address)]};
            else
                bus.mem_read_data <= {mem[int'(bus.mem_address)], mem[int'(bus.mem_address) + 1]};
        end
    end

    always @(negedge clk) begin
        if (bus.mem_rd && bus.mem_wn) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic w, input logic b, input logic s,
                                   input logic [15:0] a, input logic [15:0] wd);
        exp_t e;
        logic [7:0] bv;
        e.error    = (!b && a[0]) || (32'(a) >= 32'(MEM_BYTES));
        e.is_load  = !e.error && !w;
        e.is_store = !e.error && w;
        e.data     = 16'h0000;
        if (e.error) begin
            e.lat = 1;
        end else if (w) begin
            e.lat = 2;
            if (b) begin
                ref_mem[int'(a)] = wd[7:0];
            end else begin
                ref_mem[int'(a)]     = wd[15:8];
                ref_mem[int'(a) + 1] = wd[7:0];
            end
        end else begin
            e.lat = 3;
            if (b) begin
                bv     = ref_mem[int'(a)];
                e.data = {{8{bv[7] & s}}, bv};
            end else begin
                e.data = {ref_mem[int'(a)], ref_mem[int'(a) + 1]};
            end
        end
        return e;
    endfunction

    task automatic issue(input logic w, input logic b, input logic s,
                         input logic [15:0] a, input logic [15:0] wd, input int hold);
        exp_t        got;
        int          lat;
        logic        saw_rd;
        logic        saw_wn;
        logic [15:0] held;
        sb.push_back(model(w, b, s, a, wd));
        @(negedge clk);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_byte   = b;
        bus.req_signed = s;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.resp_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat    = 1;
        saw_rd = bus.mem_rd;
        saw_wn = bus.mem_wn;
        while (!bus.resp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
            saw_rd |= bus.mem_rd;
            saw_wn |= bus.mem_wn;
        end
        got = sb.pop_front();
        chk("resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("latency", 32'(lat), 32'(got.lat));
        chk("resp_data", 32'(bus.resp_data), 32'(got.data));
        chk("resp_error", 32'(bus.resp_error), 32'(got.error));
        chk("mem_rd_seen", 32'(saw_rd), 32'(got.is_load));
        chk("mem_wn_seen", 32'(saw_wn), 32'(got.is_store));
        if (hold > 0) begin
            held = bus.resp_data;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                bus.req_valid = 1'b1;
                bus.req_write = 1'b1;
                bus.req_byte  = 1'b0;
                bus.req_addr  = 16'h0100;
                bus.req_wdata = 16'h1234;
                @(posedge clk);
                #1;
                chk("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
                chk("hold_resp_data", 32'(bus.resp_data), 32'(held));
                chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
                chk("hold_no_write", 32'(bus.mem_wn), 32'd0);
            end
            bus.req_valid  = 1'b0;
            bus.resp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("resp_taken", 32'(bus.resp_valid), 32'd0);
    endtask

    initial begin
        logic        w, b, s;
        logic [15:0] a;
        int          r;
        rst            = 1'b1;
        mem_init       = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_byte   = 1'b0;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = 16'h0000;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = 8'(i * 37 + 5);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", 32'(bus.resp_data), 32'd0);
        chk("rst_resp_error", 32'(bus.resp_error), 32'd0);
        chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        chk("rst_mem_wn", 32'(bus.mem_wn), 32'd0);
        chk("rst_mem_address", 32'(bus.mem_address), 32'd0);
        chk("rst_mem_mode", 32'(bus.mem_mode), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_write_data), 32'd0);
        @(negedge clk);
        #1;
        rst      = 1'b0;
        mem_init = 1'b0;

        issue(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 0);
        issue(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 0);
        issue(1'b1, 1'b1, 1'b0, 16'h0021, 16'h1280, 0);
        issue(1'b0, 1'b1, 1'b1, 16'h0021, 16'h0000, 0);
        issue(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000, 0);
        issue(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 0);
        issue(1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000, 0);
        issue(1'b0, 1'b1, 1'b0, 16'h0800, 16'h0000, 0);
        issue(1'b1, 1'b0, 1'b0, 16'hFFFE, 16'h5555, 0);
        issue(1'b0, 1'b0, 1'b0, 16'h07FE, 16'h0000, 0);
        issue(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 4);
        issue(1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000, 0);

        // Reset in WRITE before the falling edge must suppress the memory write
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_byte  = 1'b0;
        bus.req_addr  = 16'h0010;
        bus.req_wdata = 16'h1111;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("write_wn_high", 32'(bus.mem_wn), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_wn_drop", 32'(bus.mem_wn), 32'd0);
        chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mid_address", 32'(bus.mem_address), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        issue(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 0);

        // Reset during a load abandons it with no response
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0010;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("load_rd_high", 32'(bus.mem_rd), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_rd_drop", 32'(bus.mem_rd), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("abandon_no_resp", 32'(bus.resp_valid), 32'd0);
        end

        for (int n = 0; n < 1000; n++) begin
            w = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 15));
            a = (r == 0) ? 16'($urandom_range(2048, 65535)) : 16'($urandom_range(0, 2047));
            issue(w, b, s, a, 16'($urandom), 0);
        end

        chk("rd_wn_overlap", 32'(both_cnt), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_BYTES, default 2048: number of addressable bytes in the attached data memory.
REQ-002 Parameter ADDR_W, default 16: width of request and memory addresses.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  CPU request present.
REQ-006 req_ready  output  1  unit can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_byte  input  1  1 = byte access, 0 = 16-bit word access.
REQ-009 req_signed  input  1  byte load sign-extends when 1, zero-extends when 0.
REQ-010 req_addr  input  ADDR_W  byte address.
REQ-011 req_wdata  input  16  store data; byte stores use [7:0].
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  CPU accepts response.
REQ-014 resp_data  output  16  load result; 0 for stores and errors.
REQ-015 resp_error  output  1  request rejected, no memory access made.
REQ-016 mem_rd  output  1  memory read strobe.
REQ-017 mem_wn  output  1  memory write strobe.
REQ-018 mem_address  output  16  memory byte address.
REQ-019 mem_mode  output  2  2'b00 word, 2'b01 byte.
REQ-020 mem_write_data  output  16  memory write data.
REQ-021 mem_read_data  input  16  memory read data, registered by memory on the rising edge where mem_rd=1.

Function
REQ-022 FSM states SHALL be IDLE, WRITE, READ, CAPT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-023 On a rising edge with req_valid & req_ready, the unit SHALL latch write, byte, signed, addr, wdata.
REQ-024 Error check at acceptance: word access with addr[0]=1, or addr >= MEM_BYTES, SHALL go IDLE->RESP with resp_error=1 and resp_data=0, and never assert mem_rd or mem_wn.
REQ-025 Valid store: IDLE->WRITE (exactly 1 cycle, mem_wn=1, mem_rd=0) -> RESP; the memory commits on that cycle's falling edge.
REQ-026 Valid load: IDLE->READ (exactly 1 cycle, mem_rd=1, mem_wn=0) -> CAPT (1 cycle, mem_rd=0) -> RESP; resp_data SHALL be registered from mem_read_data at the end of CAPT.
REQ-027 mem_rd and mem_wn SHALL never both be 1; both SHALL be 0 outside READ and WRITE.
REQ-028 mem_address, mem_mode and mem_write_data SHALL hold the latched values from acceptance until the next acceptance.
REQ-029 mem_mode SHALL be 2'b01 when byte=1, otherwise 2'b00.
REQ-030 Byte load result: {8{rd[7]&signed}, rd[7:0]}; word load result: rd[15:0] unchanged (rd[15:8] = byte at addr, rd[7:0] = byte at addr+1).
REQ-031 RESP SHALL hold resp_valid=1 with stable resp_data/resp_error until a rising edge with resp_ready=1, then go to IDLE.
REQ-032 Latency from acceptance edge to resp_valid: store 2 cycles, load 3 cycles, error 1 cycle, with resp_ready held at 1.
REQ-033 A request offered while req_ready=0 SHALL be ignored and not latched.
REQ-034 Back-to-back requests: a new request is accepted on the first rising edge in IDLE after the RESP handshake; maximum throughput is one store per 3 cycles.

Reset
REQ-035 rst=1 SHALL immediately force IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_error=0, mem_rd=0, mem_wn=0, mem_address=0, mem_mode=2'b00, mem_write_data=0.
REQ-036 Reset asserted in WRITE before the falling edge SHALL deassert mem_wn so that no memory write occurs; a load in progress SHALL be abandoned without a response.

Verification
REQ-037 Word store 0xBEEF @0x0010, then word load @0x0010 -> resp_data=0xBEEF, resp_error=0; resp_valid at +2 cycles (store) and +3 cycles (load).
REQ-038 Byte store 0x80 @0x0021, then byte load signed -> 0xFF80; byte load unsigned -> 0x0080.
REQ-039 Word load @0x0011 -> resp_error=1, resp_data=0, 1-cycle latency, mem_rd never 1; load @0x0800 -> resp_error=1.
REQ-040 Load completes while resp_ready=0 for 4 cycles -> resp_valid and resp_data stable, req_ready=0 throughout; the request offered during the hold is ignored.
REQ-041 rst pulsed during WRITE before the falling edge -> mem_wn drops at once; a later load of that address returns the prior value.
REQ-042 Random mix of 1000 requests checked against a byte-array model -> all results match; mem_rd & mem_wn never both 1.
